// File: rtl/brent_kung_adder_pipe.sv
// rtl/brent_kung_adder_pipe.sv - parametrised pipelined Brent-Kung adder/subtractor with tag sideband
module brent_kung_adder_pipe #(
  parameter int WIDTH    = 16,
  parameter int REG_PRE  = 0,
  parameter int REG_UP   = 1,
  parameter int REG_DOWN = 0,
  parameter int TAG_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             carry_i,
  input  logic             sub_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int LVL = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("brent_kung_adder_pipe: WIDTH must be a power of two >= 4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("brent_kung_adder_pipe: TAG_W must be >= 1");
  end

  // One pipeline slot: hp keeps the raw half-sum for the final XOR,
  // g/p evolve through the carry tree. Carry-in is folded into g[0], so
  // after the tree g[i] is the carry out of bit i.
  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic             cin;
    logic [WIDTH-1:0] hp;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } stage_t;

  // Up-sweep: black cells at nodes i = k*2^(l+1)-1, combining with i-2^l.
  function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LVL; l++) begin
      for (int i = (2 ** (l + 1)) - 1; i < WIDTH; i += 2 ** (l + 1)) begin
        g[i] = g[i] | (p[i] & g[i - (2 ** l)]);
        p[i] = p[i] & p[i - (2 ** l)];
      end
    end
    return {g, p};
  endfunction

  // Down-sweep: gray cells fill the remaining prefixes; only G is needed.
  function automatic logic [WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    g = g_in;
    for (int l = LVL - 2; l >= 0; l--) begin
      for (int i = 3 * (2 ** l) - 1; i < WIDTH; i += 2 ** (l + 1)) begin
        g[i] = g[i] | (p_in[i] & g[i - (2 ** l)]);
      end
    end
    return g;
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] carry_vec;
  logic             unused_dn_p;
  stage_t           pre_c, pre_q, up_c, up_q, dn_c, dn_q;

  // Only the output stage can stall; every other stage follows it.
  assign en      = !valid_o || ready_i;
  assign ready_o = en;
  assign b_eff   = sub_i ? ~op2_i : op2_i;

  // Pre-processing: per-bit generate/propagate with carry-in merged into bit 0.
  always_comb begin
    pre_c      = '0;
    pre_c.v    = valid_i;
    pre_c.tag  = tag_i;
    pre_c.cin  = sub_i ? ~carry_i : carry_i;
    pre_c.hp   = op1_i ^ b_eff;
    pre_c.p    = op1_i ^ b_eff;
    pre_c.g    = op1_i & b_eff;
    pre_c.g[0] = (op1_i[0] & b_eff[0]) | (pre_c.hp[0] & pre_c.cin);
  end

  if (REG_PRE != 0) begin : g_pre_reg
    // Optional cut after p/g generation.
    always_ff @(posedge clk_i) begin
      if (rst_i)   pre_q <= '0;
      else if (en) pre_q <= pre_c;
    end
  end else begin : g_pre_wire
    assign pre_q = pre_c;
  end

  // Reduction half of the carry tree.
  always_comb begin
    up_c              = pre_q;
    {up_c.g, up_c.p}  = up_sweep(pre_q.g, pre_q.p);
  end

  if (REG_UP != 0) begin : g_up_reg
    // Optional cut after the up-sweep.
    always_ff @(posedge clk_i) begin
      if (rst_i)   up_q <= '0;
      else if (en) up_q <= up_c;
    end
  end else begin : g_up_wire
    assign up_q = up_c;
  end

  // Distribution half of the carry tree.
  always_comb begin
    dn_c   = up_q;
    dn_c.g = down_sweep(up_q.g, up_q.p);
  end

  if (REG_DOWN != 0) begin : g_dn_reg
    // Optional cut after the down-sweep.
    always_ff @(posedge clk_i) begin
      if (rst_i)   dn_q <= '0;
      else if (en) dn_q <= dn_c;
    end
  end else begin : g_dn_wire
    assign dn_q = dn_c;
  end

  // Carry into bit i is the prefix carry out of bit i-1; bit 0 sees cin.
  assign carry_vec   = {dn_q.g[WIDTH-2:0], dn_q.cin};
  assign unused_dn_p = ^dn_q.p;

  // Output register: data only loads with a valid result so it holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      tag_o      <= '0;
    end else if (en) begin
      valid_o <= dn_q.v;
      if (dn_q.v) begin
        sum_o      <= dn_q.hp ^ carry_vec;
        carry_o    <= dn_q.g[WIDTH-1];
        overflow_o <= dn_q.g[WIDTH-1] ^ dn_q.g[WIDTH-2];
        tag_o      <= dn_q.tag;
      end
    end
  end

endmodule

// File: tb/tb_brent_kung_adder_pipe.sv
// tb/tb_brent_kung_adder_pipe.sv - directed and randomised checks of brent_kung_adder_pipe
module tb_brent_kung_adder_pipe;

  localparam int NC = 10;

  function automatic int cfg_w(input int k);
    if (k == 0) return 16;
    case ((k - 1) / 3)
      0:       return 8;
      1:       return 32;
      default: return 64;
    endcase
  endfunction
  function automatic int cfg_pre(input int k);
    return (k != 0 && (k - 1) % 3 == 1) ? 1 : 0;
  endfunction
  function automatic int cfg_up(input int k);
    return (k == 0 || (k - 1) % 3 != 0) ? 1 : 0;
  endfunction
  function automatic int cfg_lat(input int k);
    return 1 + cfg_pre(k) + cfg_up(k) + cfg_pre(k);
  endfunction

  logic        clk = 1'b0;
  logic        rst   [NC];
  logic        vin   [NC];
  logic        rdy_o [NC];
  logic        vout  [NC];
  logic        rdy_i [NC];
  logic        cin   [NC];
  logic        sub   [NC];
  logic        cout  [NC];
  logic        ovf   [NC];
  logic [63:0] a     [NC];
  logic [63:0] b     [NC];
  logic [63:0] s     [NC];
  logic [3:0]  tgi   [NC];
  logic [3:0]  tgo   [NC];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NC; k++) begin : g_dut
    localparam int W = cfg_w(k);
    logic [W-1:0] s_w;
    brent_kung_adder_pipe #(
      .WIDTH(W), .REG_PRE(cfg_pre(k)), .REG_UP(cfg_up(k)), .REG_DOWN(cfg_pre(k)), .TAG_W(4)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[k]), .valid_i(vin[k]), .ready_o(rdy_o[k]),
      .op1_i(a[k][W-1:0]), .op2_i(b[k][W-1:0]), .carry_i(cin[k]), .sub_i(sub[k]),
      .tag_i(tgi[k]), .valid_o(vout[k]), .ready_i(rdy_i[k]), .sum_o(s_w),
      .carry_o(cout[k]), .overflow_o(ovf[k]), .tag_o(tgo[k])
    );
    assign s[k] = 64'(s_w);
  end

  typedef struct {
    logic [15:0] a, b;
    logic        ci, sb;
    logic [3:0]  tag;
    logic [15:0] s;
    logic        c, o;
  } vec_t;

  typedef struct {
    logic [63:0] s;
    logic        c, o;
    logic [3:0]  tag;
    int          acc;
    int          stl;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Behavioural reference: {overflow, carry, sum} for a w-bit operation.
  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sb);
    logic [63:0] m, xa, be, sm;
    logic [64:0] full;
    logic        c, o;
    m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    xa   = x & m;
    be   = (sb ? ~y : y) & m;
    full = {1'b0, xa} + {1'b0, be} + {64'd0, (sb ? ~ci : ci)};
    sm   = full[63:0] & m;
    c    = full[w];
    o    = (xa[w-1] == be[w-1]) && (sm[w-1] != xa[w-1]);
    return {o, c, sm};
  endfunction

  task automatic one_op(input int k, input logic [63:0] x, input logic [63:0] y, input logic ci,
                        input logic sb, input logic [3:0] tg, input logic [63:0] es,
                        input logic ec, input logic eo, input string nm);
    int lat;
    @(negedge clk);
    a[k] = x; b[k] = y; cin[k] = ci; sub[k] = sb; tgi[k] = tg; vin[k] = 1'b1; rdy_i[k] = 1'b1;
    #1 chk({nm, "_ready"}, 64'(rdy_o[k]), 64'd1);
    @(posedge clk);
    #1 vin[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vout[k] && lat < 20);
    chk({nm, "_latency"}, 64'(lat), 64'(cfg_lat(k)));
    chk({nm, "_sum"},     s[k],          es);
    chk({nm, "_carry"},   64'(cout[k]),  64'(ec));
    chk({nm, "_ovf"},     64'(ovf[k]),   64'(eo));
    chk({nm, "_tag"},     64'(tgo[k]),   64'(tg));
  endtask

  task automatic backpressure();
    int          sent, got, cyc, first;
    logic [63:0] snap_s;
    logic [3:0]  snap_t;
    logic        stall;
    sent = 0; got = 0; cyc = 0; first = -1; snap_s = '0; snap_t = '0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      if (vout[0] && first < 0) first = cyc;
      stall    = (first >= 0) && (cyc < first + 3);
      rdy_i[0] = !stall;
      vin[0]   = (sent < 6);
      a[0]     = 64'(sent) * 64'h1111;
      b[0]     = 64'h0101;
      cin[0]   = 1'b0;
      sub[0]   = 1'b0;
      tgi[0]   = 4'(sent);
      #1;
      if (stall) begin
        chk("bp_ready_low", 64'(rdy_o[0]), 64'd0);
        if (cyc == first) begin
          snap_s = s[0];
          snap_t = tgo[0];
        end else begin
          chk("bp_valid_held", 64'(vout[0]), 64'd1);
          chk("bp_sum_frozen", s[0], snap_s);
          chk("bp_tag_frozen", 64'(tgo[0]), 64'(snap_t));
        end
      end
      if (vout[0] && rdy_i[0]) begin
        chk("bp_tag_order", 64'(tgo[0]), 64'(got));
        chk("bp_sum", s[0], 64'(got) * 64'h1111 + 64'h0101);
        got++;
      end
      if (vin[0] && rdy_o[0]) sent++;
      cyc++;
    end
    vin[0] = 1'b0; rdy_i[0] = 1'b1;
    chk("bp_all_delivered", 64'(got), 64'd6);
    repeat (4) begin
      @(negedge clk);
      chk("bp_no_duplicate", 64'(vout[0]), 64'd0);
    end
  endtask

  task automatic run_rand(input int k, input int nops);
    exp_t        q[$];
    exp_t        e;
    logic [65:0] m;
    int          w, lat, cyc, stalls, issued;
    logic        hold, seen;
    w = cfg_w(k); lat = cfg_lat(k); cyc = 0; stalls = 0; issued = 0; hold = 1'b0; seen = 1'b0;
    while ((issued < nops || q.size() > 0) && cyc < nops * 8 + 200) begin
      @(negedge clk);
      if (!hold) begin
        vin[k] = (issued < nops) && ($urandom_range(0, 3) != 0);
        a[k]   = {$urandom, $urandom};
        b[k]   = {$urandom, $urandom};
        cin[k] = 1'($urandom_range(0, 1));
        sub[k] = 1'($urandom_range(0, 1));
        tgi[k] = 4'($urandom);
      end
      rdy_i[k] = (issued >= nops) || ($urandom_range(0, 3) != 0);
      #1;
      if (vout[k] && q.size() > 0 && !seen) begin
        seen = 1'b1;
        if (q[0].stl == stalls) chk("rand_latency", 64'(cyc - q[0].acc), 64'(lat));
      end
      if (vout[k] && rdy_i[k]) begin
        if (q.size() == 0) begin
          chk("rand_extra_result", 64'(vout[k]), 64'd0);
        end else begin
          e = q.pop_front();
          chk("rand_sum",   s[k],          e.s);
          chk("rand_carry", 64'(cout[k]),  64'(e.c));
          chk("rand_ovf",   64'(ovf[k]),   64'(e.o));
          chk("rand_tag",   64'(tgo[k]),   64'(e.tag));
          seen = 1'b0;
        end
      end
      if (vin[k] && rdy_o[k]) begin
        m     = model(w, a[k], b[k], cin[k], sub[k]);
        e.s   = m[63:0];
        e.c   = m[64];
        e.o   = m[65];
        e.tag = tgi[k];
        e.acc = cyc;
        e.stl = stalls;
        q.push_back(e);
        issued++;
      end
      hold = vin[k] && !rdy_o[k];
      if (!rdy_o[k]) stalls++;
      cyc++;
    end
    vin[k] = 1'b0; rdy_i[k] = 1'b1;
    chk($sformatf("rand_cfg%0d_drained", k), 64'(q.size()), 64'd0);
    chk($sformatf("rand_cfg%0d_issued", k), 64'(issued), 64'(nops));
  endtask

  task automatic reset_flight(input int k);
    @(negedge clk);
    rdy_i[k] = 1'b1; vin[k] = 1'b1; a[k] = 64'h11; b[k] = 64'h22; cin[k] = 1'b0; sub[k] = 1'b0;
    tgi[k] = 4'h1;
    @(posedge clk);
    #1 a[k] = 64'h33; tgi[k] = 4'h2;
    @(posedge clk);
    #1 a[k] = 64'h44; tgi[k] = 4'h3; rst[k] = 1'b1;
    @(posedge clk);
    #1 rst[k] = 1'b0; vin[k] = 1'b0;
    @(negedge clk);
    chk("rst_valid",  64'(vout[k]),  64'd0);
    chk("rst_sum",    s[k],          64'd0);
    chk("rst_carry",  64'(cout[k]),  64'd0);
    chk("rst_ovf",    64'(ovf[k]),   64'd0);
    chk("rst_tag",    64'(tgo[k]),   64'd0);
    chk("rst_ready",  64'(rdy_o[k]), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("rst_no_ghost", 64'(vout[k]), 64'd0);
    end
    one_op(k, 64'hF0, 64'h20, 1'b0, 1'b0, 4'h6, 64'h10, 1'b1, 1'b0, "rst_after");
  endtask

  initial begin
    vec_t vt[11];
    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'hA, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h1, 16'h8000, 1'b0, 1'b1};
    vt[2]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 4'h2, 16'h5556, 1'b0, 1'b0};
    vt[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 4'h3, 16'hFFFE, 1'b0, 1'b0};
    vt[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 4'h4, 16'h7FFF, 1'b1, 1'b1};
    vt[5]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 4'h5, 16'h000E, 1'b1, 1'b0};
    vt[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 4'h6, 16'h0001, 1'b0, 1'b0};
    vt[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 4'h7, 16'h0000, 1'b1, 1'b1};
    vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4'h8, 16'hFFFF, 1'b1, 1'b0};
    vt[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 4'h9, 16'h8000, 1'b0, 1'b1};
    vt[10] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 4'hF, 16'hFFFF, 1'b0, 1'b0};

    for (int k = 0; k < NC; k++) begin
      rst[k] = 1'b1; vin[k] = 1'b0; rdy_i[k] = 1'b1; a[k] = '0; b[k] = '0;
      cin[k] = 1'b0; sub[k] = 1'b0; tgi[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(vout[0]), 64'd0);
    chk("reset_sum",   s[0],         64'd0);
    chk("reset_carry", 64'(cout[0]), 64'd0);
    chk("reset_ovf",   64'(ovf[0]),  64'd0);
    chk("reset_tag",   64'(tgo[0]),  64'd0);
    for (int k = 0; k < NC; k++) rst[k] = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(rdy_o[0]), 64'd1);

    for (int i = 0; i < 11; i++) begin
      one_op(0, 64'(vt[i].a), 64'(vt[i].b), vt[i].ci, vt[i].sb, vt[i].tag,
             64'(vt[i].s), vt[i].c, vt[i].o, $sformatf("vec%0d", i));
    end

    backpressure();

    for (int k = 0; k < NC; k++) run_rand(k, 3000);

    reset_flight(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
